test_pattern_480p: RTL

- Pixel-colour stage directly downstream of the simple_480p timing generator. Consumes its screen coordinates and sync/DE, and produces registered RGB565 plus delay-matched HSYNC/VSYNC/DE for the DVI transmitter pins.
- Supports four selectable test patterns, including an animated bouncing box.
- Pattern selection and animation update only at frame boundaries, so there is no tearing.

---
 rtl/test_pattern_480p_pkg.sv | 45 ++++
 rtl/test_pattern_480p_bounce_axis.sv | 57 +++++
 rtl/test_pattern_480p.sv | 101 ++++++++++
 3 files changed

// File: rtl/test_pattern_480p_pkg.sv
// Shared types and constants for the 480p test-pattern stage: RGB565 layout,
// named colours and pattern-mode encodings.
package test_pattern_480p_pkg;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  localparam rgb565_t BLACK     = '{r: 5'd0,  g: 6'd0,  b: 5'd0};
  localparam rgb565_t WHITE     = '{r: 5'd31, g: 6'd63, b: 5'd31};
  localparam rgb565_t YELLOW    = '{r: 5'd31, g: 6'd63, b: 5'd0};
  localparam rgb565_t CYAN      = '{r: 5'd0,  g: 6'd63, b: 5'd31};
  localparam rgb565_t GREEN_C   = '{r: 5'd0,  g: 6'd63, b: 5'd0};
  localparam rgb565_t MAGENTA   = '{r: 5'd31, g: 6'd0,  b: 5'd31};
  localparam rgb565_t RED_C     = '{r: 5'd31, g: 6'd0,  b: 5'd0};
  localparam rgb565_t BLUE_C    = '{r: 5'd0,  g: 6'd0,  b: 5'd31};
  localparam rgb565_t DARK_BLUE = '{r: 5'd0,  g: 6'd0,  b: 5'd8};

  typedef enum logic [1:0] {
    MODE_GRADIENT = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_BOX      = 2'd3
  } mode_e;

  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = WHITE;
      3'd1:    bar_colour = YELLOW;
      3'd2:    bar_colour = CYAN;
      3'd3:    bar_colour = GREEN_C;
      3'd4:    bar_colour = MAGENTA;
      3'd5:    bar_colour = RED_C;
      3'd6:    bar_colour = BLUE_C;
      default: bar_colour = BLACK;
    endcase
  endfunction

endpackage

// File: rtl/test_pattern_480p_bounce_axis.sv
// One axis of the bouncing box: position/direction state that steps once per
// frame strobe and reflects off 0 and LIMIT-SIZE.
module bounce_axis #(
  parameter int CORDW = 10,
  parameter int LIMIT = 640,
  parameter int SIZE  = 32,
  parameter int SPEED = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [CORDW-1:0] pos_o
);

  localparam int W1   = CORDW + 1;
  localparam int MAXP = LIMIT - SIZE;

  logic [CORDW-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [W1-1:0]    nx;

  // One extra bit so pos+SPEED cannot wrap before the clamp compare.
  assign nx = {1'b0, pos_q} + W1'(SPEED);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (step_i) begin
      if (dir_q) begin
        if (nx >= W1'(MAXP)) begin
          pos_d = CORDW'(MAXP);
          dir_d = 1'b0;
        end else begin
          pos_d = nx[CORDW-1:0];
        end
      end else if ({1'b0, pos_q} <= W1'(SPEED)) begin
        pos_d = '0;
        dir_d = 1'b1;
      end else begin
        pos_d = pos_q - CORDW'(SPEED);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_q <= '0;
      dir_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/test_pattern_480p.sv
// Test-pattern colour stage behind the 480p timing generator: four patterns,
// frame-synchronous mode/animation update, 2-cycle registered RGB565 + syncs.
module test_pattern_480p
  import test_pattern_480p_pkg::*;
#(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_SPEED = 2
) (
  input  logic             PCLK,
  input  logic             RST_PCLK,
  input  logic [CORDW-1:0] SX,
  input  logic [CORDW-1:0] SY,
  input  logic             DE_IN,
  input  logic             HSYNC_IN,
  input  logic             VSYNC_IN,
  input  logic [1:0]       MODE,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             DE,
  output logic [R_W-1:0]   RED,
  output logic [G_W-1:0]   GREEN,
  output logic [B_W-1:0]   BLUE
);

  localparam int W1    = CORDW + 1;
  localparam int BAR_W = H_RES / 8;

  logic             fs;
  mode_e            mode_q;
  logic [CORDW-1:0] bx, by;
  logic             in_box;
  logic [2:0]       bar;
  rgb565_t          col_d, col_q, rgb_q;
  logic [2:1]       de_pipe_q, hs_pipe_q, vs_pipe_q;

  // First pixel of vertical blanking: mode and box only change here.
  assign fs = (SX == '0) && (SY == CORDW'(V_RES));

  always_ff @(posedge PCLK) begin
    if (RST_PCLK)  mode_q <= MODE_GRADIENT;
    else if (fs)   mode_q <= mode_e'(MODE);
  end

  bounce_axis #(.CORDW(CORDW), .LIMIT(H_RES), .SIZE(BOX_SIZE), .SPEED(BOX_SPEED)) u_axis_x (
    .clk_i(PCLK), .rst_i(RST_PCLK), .step_i(fs), .pos_o(bx)
  );

  bounce_axis #(.CORDW(CORDW), .LIMIT(V_RES), .SIZE(BOX_SIZE), .SPEED(BOX_SPEED)) u_axis_y (
    .clk_i(PCLK), .rst_i(RST_PCLK), .step_i(fs), .pos_o(by)
  );

  assign in_box = ({1'b0, SX} >= {1'b0, bx}) && ({1'b0, SX} < {1'b0, bx} + W1'(BOX_SIZE)) &&
                  ({1'b0, SY} >= {1'b0, by}) && ({1'b0, SY} < {1'b0, by} + W1'(BOX_SIZE));

  always_comb begin
    col_d = BLACK;
    bar   = '0;
    // Bar index by threshold compares; avoids a divide by 80.
    for (int i = 1; i < 8; i++)
      if (SX >= CORDW'(i * BAR_W)) bar = 3'(i);
    case (mode_q)
      MODE_GRADIENT: begin
        if (SX < CORDW'(256) && SY < CORDW'(256)) begin
          col_d.r = {SY[7:6], SX[7:5]};
          col_d.g = SY[5:0];
          col_d.b = SX[4:0];
        end
      end
      MODE_BARS:    col_d = bar_colour(bar);
      MODE_CHECKER: col_d = (SX[5] ^ SY[5]) ? WHITE : BLACK;
      default:      col_d = in_box ? WHITE : DARK_BLUE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (RST_PCLK) begin
      col_q     <= BLACK;
      rgb_q     <= BLACK;
      de_pipe_q <= '0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      col_q     <= col_d;
      rgb_q     <= de_pipe_q[1] ? col_q : BLACK;
      de_pipe_q <= {de_pipe_q[1], DE_IN};
      hs_pipe_q <= {hs_pipe_q[1], HSYNC_IN};
      vs_pipe_q <= {vs_pipe_q[1], VSYNC_IN};
    end
  end

  assign HSYNC = hs_pipe_q[2];
  assign VSYNC = vs_pipe_q[2];
  assign DE    = de_pipe_q[2];
  assign RED   = rgb_q.r;
  assign GREEN = rgb_q.g;
  assign BLUE  = rgb_q.b;

endmodule
